// File: rtl/axi_line_arbiter.sv
// axi_line_arbiter: shares one cache-line AXI engine between the icache and
// the dcache. One transaction at a time; the winner's address, write line,
// op and owner are latched, and the completion pulse plus read line are
// routed back to the owner only.
module axi_line_arbiter #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       i_rd_req,
  input  logic [ADDR_W-1:0]          i_addr,
  output logic                       i_gnt,
  output logic [LINE_WORDS*32-1:0]   i_rd_line,
  input  logic                       d_rd_req,
  input  logic                       d_wr_req,
  input  logic [ADDR_W-1:0]          d_addr,
  input  logic [LINE_WORDS*32-1:0]   d_wr_line,
  output logic                       d_gnt,
  output logic [LINE_WORDS*32-1:0]   d_rd_line,
  output logic                       m_rd_req,
  output logic                       m_wr_req,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [LINE_WORDS*32-1:0]   m_wr_line,
  input  logic                       m_gnt,
  input  logic [LINE_WORDS*32-1:0]   m_rd_line,
  output logic                       busy,
  output logic [1:0]                 owner
);

  localparam int unsigned LW = LINE_WORDS * 32;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: dcache owned the last transaction
  logic              op_wr_q, op_wr_d;
  logic [1:0]        own_q, own_d;         // 01 icache, 10 dcache
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     wline_q, wline_d;

  logic i_cand, d_cand, pick_d, gnt_v;

  assign i_cand = i_rd_req;
  assign d_cand = d_rd_req | d_wr_req;
  // D wins if alone, under fixed priority, or when I was served last.
  assign pick_d = d_cand & (~i_cand | (FIXED_PRIO != 0) | ~last_d_q);

  // State and transaction latches.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      last_d_q <= 1'b0;
      op_wr_q  <= 1'b0;
      own_q    <= '0;
      addr_q   <= '0;
      wline_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      op_wr_q  <= op_wr_d;
      own_q    <= own_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
    end
  end

  // Next state: arbitrate in IDLE, wait for engine completion in BUSY.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    op_wr_d  = op_wr_q;
    own_d    = own_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    case (state_q)
      S_IDLE: begin
        if (i_cand || d_cand) begin
          state_d = S_BUSY;
          if (pick_d) begin
            // A pending write-back goes first; the read is re-arbitrated later.
            own_d   = 2'b10;
            op_wr_d = d_wr_req;
            addr_d  = d_addr;
            if (d_wr_req) wline_d = d_wr_line;
          end else begin
            own_d   = 2'b01;
            op_wr_d = 1'b0;
            addr_d  = i_addr;
          end
        end
      end
      S_BUSY: begin
        if (m_gnt) begin
          state_d  = S_DONE;
          last_d_d = own_q[1];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: engine requests from latched op, gnt routed to the owner only.
  always_comb begin
    busy      = (state_q != S_IDLE);
    owner     = busy ? own_q : 2'b00;
    m_rd_req  = (state_q == S_BUSY) & ~op_wr_q;
    m_wr_req  = (state_q == S_BUSY) &  op_wr_q;
    m_addr    = addr_q;
    m_wr_line = wline_q;
    gnt_v     = (state_q == S_BUSY) & m_gnt;
    i_gnt     = gnt_v & (own_q == 2'b01);
    d_gnt     = gnt_v & (own_q == 2'b10);
    i_rd_line = i_gnt ? m_rd_line : '0;
    d_rd_line = d_gnt ? m_rd_line : '0;
  end

endmodule

// File: tb/tb_axi_line_arbiter.sv
// Bench for axi_line_arbiter: directed scenarios plus randomized requests,
// checked against a transaction-level arbitration model.
module tb_axi_line_arbiter;
  localparam int LW = 256;

  logic          aclk = 0, aresetn = 0;
  logic          i_rd_req = 0, d_rd_req = 0, d_wr_req = 0, m_gnt = 0;
  logic [31:0]   i_addr = 0, d_addr = 0;
  logic [LW-1:0] d_wr_line = '0, m_rd_line = '0;
  logic          i_gnt, d_gnt, m_rd_req, m_wr_req, busy;
  logic [LW-1:0] i_rd_line, d_rd_line, m_wr_line;
  logic [31:0]   m_addr;
  logic [1:0]    owner;

  int checks = 0, failures = 0;
  bit model_last_d = 0;   // model: 1 when dcache owned the last transaction

  axi_line_arbiter #(.LINE_WORDS(8), .ADDR_W(32), .FIXED_PRIO(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_rd_req(i_rd_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rd_line(i_rd_line),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wr_line(d_wr_line),
    .d_gnt(d_gnt), .d_rd_line(d_rd_line),
    .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_addr(m_addr), .m_wr_line(m_wr_line),
    .m_gnt(m_gnt), .m_rd_line(m_rd_line), .busy(busy), .owner(owner)
  );

  always #5 aclk = ~aclk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic apply_reset();
    aresetn = 0; step(); step();
    aresetn = 1; model_last_d = 0; step();
  endtask

  // Plays the line engine for one transaction and checks the arbiter around it.
  task automatic serve(input bit exp_wr, input logic [1:0] exp_own,
                       input logic [31:0] exp_addr, input logic [LW-1:0] exp_wline,
                       input logic [LW-1:0] ln, input int lat, input bit perturb,
                       output int waited);
    bit ok;
    waited = 0;
    while (!(m_rd_req || m_wr_req) && waited < 20) begin step(); waited++; end
    checks++;
    if (waited >= 20) begin
      failures++; $display("FAIL req_timeout: m_rd_req=%b m_wr_req=%b required a request", m_rd_req, m_wr_req);
      return;
    end
    checks++;
    if ({m_wr_req, m_rd_req, owner, busy} !== {exp_wr, !exp_wr, exp_own, 1'b1}) begin
      failures++; $display("FAIL req_kind: wr=%b rd=%b owner=%b busy=%b required wr=%b rd=%b owner=%b busy=1",
                           m_wr_req, m_rd_req, owner, busy, exp_wr, !exp_wr, exp_own);
    end
    checks++;
    if (m_addr !== exp_addr) begin
      failures++; $display("FAIL req_addr: m_addr=%h required %h", m_addr, exp_addr);
    end
    if (exp_wr) begin
      checks++;
      if (m_wr_line !== exp_wline) begin
        failures++; $display("FAIL wr_line: m_wr_line[31:0]=%h required %h", m_wr_line[31:0], exp_wline[31:0]);
      end
    end
    if (perturb) begin
      i_addr = 32'h0000_2000; d_addr = $urandom; i_rd_req = 0;
    end
    ok = 1;
    for (int c = 0; c < lat; c++) begin
      step();
      if (m_rd_req !== !exp_wr || m_wr_req !== exp_wr || m_addr !== exp_addr || i_gnt || d_gnt) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL hold: request/address not held or early gnt, m_addr=%h required %h", m_addr, exp_addr);
    end
    m_rd_line = ln; m_gnt = 1; #1;
    checks++;
    if (i_gnt !== (exp_own == 2'b01) || d_gnt !== (exp_own == 2'b10)) begin
      failures++; $display("FAIL gnt_route: i_gnt=%b d_gnt=%b required owner=%b", i_gnt, d_gnt, exp_own);
    end
    checks++;
    if ((exp_own == 2'b01 && (i_rd_line !== ln || d_rd_line !== '0)) ||
        (exp_own == 2'b10 && (d_rd_line !== ln || i_rd_line !== '0))) begin
      failures++; $display("FAIL rd_line: i_rd_line[31:0]=%h d_rd_line[31:0]=%h required %h to owner %b",
                           i_rd_line[31:0], d_rd_line[31:0], ln[31:0], exp_own);
    end
    @(posedge aclk); #1;
    m_gnt = 0; m_rd_line = '0;
    model_last_d = (exp_own == 2'b10);
    checks++;
    if (m_rd_req !== 0 || m_wr_req !== 0 || busy !== 1 || i_gnt || d_gnt) begin
      failures++; $display("FAIL done_cycle: rd=%b wr=%b busy=%b required 0 0 1", m_rd_req, m_wr_req, busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({i_gnt, d_gnt, m_rd_req, m_wr_req, busy, owner} !== '0 || m_addr !== '0 ||
        m_wr_line !== '0 || i_rd_line !== '0 || d_rd_line !== '0) begin
      failures++; $display("FAIL reset_state: busy=%b owner=%b m_addr=%h required all zero", busy, owner, m_addr);
    end
  endtask

  task automatic test_single_i();
    logic [LW-1:0] ln;
    int w;
    for (int k = 0; k < 8; k++) ln[k*32 +: 32] = 32'h11 * (k + 1);
    i_addr = 32'h1FC0_0020; i_rd_req = 1;
    serve(0, 2'b01, 32'h1FC0_0020, '0, ln, 10, 0, w);
    i_rd_req = 0;
    step(); step();
    checks++;
    if (busy !== 0 || m_rd_req !== 0) begin
      failures++; $display("FAIL idle_after: busy=%b m_rd_req=%b required 0 0", busy, m_rd_req);
    end
  endtask

  task automatic test_round_robin();
    int w;
    logic [1:0] exp_own;
    apply_reset();
    i_addr = 32'h0000_4000; d_addr = 32'h0000_8000;
    i_rd_req = 1; d_rd_req = 1;
    for (int r = 0; r < 4; r++) begin
      exp_own = model_last_d ? 2'b01 : 2'b10;  // both pending: the one not served last
      serve(0, exp_own, exp_own[1] ? d_addr : i_addr, '0, rand_line(), $urandom_range(0, 4), 0, w);
      if (r > 0) begin
        checks++;
        if (w !== 2) begin
          failures++; $display("FAIL b2b_spacing: waited=%0d cycles after DONE required 2", w);
        end
      end
    end
    i_rd_req = 0; d_rd_req = 0;
    step();
  endtask

  task automatic test_wr_then_rd();
    logic [LW-1:0] wl;
    int w;
    wl = rand_line(); wl[31:0] = 32'hDEAD_BEEF;
    d_addr = 32'h0000_1000; d_wr_line = wl; d_wr_req = 1; d_rd_req = 1;
    serve(1, 2'b10, 32'h0000_1000, wl, rand_line(), 3, 0, w);
    d_wr_req = 0;
    serve(0, 2'b10, 32'h0000_1000, '0, rand_line(), 2, 0, w);
    d_rd_req = 0;
    step();
  endtask

  task automatic test_addr_change();
    int w;
    i_addr = 32'h0000_1000; i_rd_req = 1;
    serve(0, 2'b01, 32'h0000_1000, '0, rand_line(), 5, 1, w);
    i_rd_req = 0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    int n;
    i_addr = 32'h0000_3000; i_rd_req = 1;
    n = 0;
    while (!m_rd_req && n < 10) begin step(); n++; end
    step();
    aresetn = 0; m_gnt = 1; #1;
    checks++;
    if ({i_gnt, d_gnt, m_rd_req, m_wr_req, busy, owner} !== '0 || m_addr !== '0) begin
      failures++; $display("FAIL async_reset: gnt=%b%b rd=%b busy=%b owner=%b m_addr=%h required all zero",
                           i_gnt, d_gnt, m_rd_req, busy, owner, m_addr);
    end
    step(); m_gnt = 0;
    aresetn = 1; model_last_d = 0;
    serve(0, 2'b01, 32'h0000_3000, '0, rand_line(), 1, 0, n);
    i_rd_req = 0;
    step();
  endtask

  task automatic test_spurious_gnt();
    step();
    m_gnt = 1; m_rd_line = rand_line(); #1;
    checks++;
    if (i_gnt !== 0 || d_gnt !== 0 || i_rd_line !== '0 || d_rd_line !== '0) begin
      failures++; $display("FAIL spurious_gnt: i_gnt=%b d_gnt=%b required 0 0", i_gnt, d_gnt);
    end
    step(); m_gnt = 0; m_rd_line = '0;
    checks++;
    if (busy !== 0 || m_rd_req !== 0 || m_wr_req !== 0) begin
      failures++; $display("FAIL spurious_state: busy=%b required 0", busy);
    end
  endtask

  task automatic test_random();
    int w;
    bit ir, dr, dw, pick_d;
    logic [LW-1:0] wl;
    for (int t = 0; t < 30; t++) begin
      do begin ir = $urandom; dr = $urandom; dw = $urandom; end while (!(ir || dr || dw));
      i_addr = $urandom; d_addr = $urandom; wl = rand_line(); d_wr_line = wl;
      i_rd_req = ir; d_rd_req = dr; d_wr_req = dw;
      if (!(dr || dw)) pick_d = 0;
      else if (!ir) pick_d = 1;
      else pick_d = !model_last_d;
      serve(pick_d && dw, pick_d ? 2'b10 : 2'b01, pick_d ? d_addr : i_addr, wl,
            rand_line(), $urandom_range(0, 6), 0, w);
      i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_round_robin();
    test_wr_then_rd();
    test_addr_change();
    test_reset_mid_busy();
    test_spurious_gnt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/axi_line_arbiter.md
Name: axi_line_arbiter

Overview:
- Shares the single cache-line AXI engine (line-level gnt/addr/rd_req/rd_line/wr_req/wr_line interface) between the instruction cache and the data cache.
- Each requester sees a private line interface with the same handshake as the engine.
- The arbiter serialises transactions, latches the winner's address and write line, and routes the completion pulse and read line back to the owner only.

Parameters:
- LINE_WORDS, 8, words per cache line; line buses are LINE_WORDS*32 bits wide, word 0 in bits [31:0].
- ADDR_W, 32, address width.
- FIXED_PRIO, 0, 0 = round-robin between I and D; 1 = D always wins ties.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- i_rd_req  in  1  icache line-read request; held until i_gnt.
- i_addr  in  ADDR_W  icache line address.
- i_gnt  out  1  one-cycle completion pulse to icache.
- i_rd_line  out  LINE_WORDS*32  read line; valid only in the i_gnt cycle.
- d_rd_req  in  1  dcache line-read request.
- d_wr_req  in  1  dcache line write-back request.
- d_addr  in  ADDR_W  dcache line address.
- d_wr_line  in  LINE_WORDS*32  write-back data.
- d_gnt  out  1  one-cycle completion pulse to dcache.
- d_rd_line  out  LINE_WORDS*32  read line; valid only in the d_gnt cycle.
- m_rd_req  out  1  read request to the line engine.
- m_wr_req  out  1  write request to the line engine.
- m_addr  out  ADDR_W  latched address.
- m_wr_line  out  LINE_WORDS*32  latched write line.
- m_gnt  in  1  engine completion pulse.
- m_rd_line  in  LINE_WORDS*32  engine read line; valid with m_gnt.
- busy  out  1  transaction in flight (state != IDLE).
- owner  out  2  00 none, 01 icache, 10 dcache.

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE, last_owner=I; all outputs 0.
  - Latched addr/line cleared to 0.
  - Assertion mid-transaction aborts immediately. No gnt is issued; requesters must re-request after reset.
- States: IDLE, BUSY, DONE.
- IDLE, sampled at the rising edge:
  - No request pending: stay in IDLE.
  - Candidates are I if i_rd_req, D if d_rd_req or d_wr_req.
  - Both pending:
    - FIXED_PRIO=1 selects D.
    - FIXED_PRIO=0 selects the requester that is not last_owner.
  - For D with both d_wr_req and d_rd_req high: write is served first, the read as a separate later transaction.
  - Winner's addr (and d_wr_line for writes) is latched, along with op and owner. Go to BUSY.
- BUSY:
  - m_rd_req or m_wr_req is held at 1 (registered, from the latched op). m_addr and m_wr_line are driven from latches.
  - Requester inputs are ignored, including deassertion or address changes.
  - When m_gnt=1: the owner's gnt is 1 in the same cycle (combinational from m_gnt & owner match), with its rd_line = m_rd_line. The other requester's gnt stays 0 and its rd_line is 0. last_owner is updated and the state goes to DONE.
- DONE:
  - m_* requests are 0 for exactly one cycle so the engine sees the request drop and the owner can drop its request.
  - Then IDLE.
  - A request still asserted by the owner in this cycle is not re-arbitrated until IDLE, where it is treated as a new request.
- Latency:
  - Request high at edge N (IDLE) gives m_*_req high from N+1.
  - Minimum back-to-back spacing is gnt, then 1 DONE cycle, then IDLE sampling, then m_req again: 3 cycles from one gnt to the next m_req.
- m_gnt outside BUSY is ignored: no gnt out, no state change.
- Never: m_rd_req and m_wr_req both high; i_gnt and d_gnt both high; gnt to a requester that is not owner.

Test Plan:
- Single I read: i_rd_req=1, i_addr=0x1FC0_0020; engine returns m_gnt after 10 cycles with line words 0..7 = 0x11..0x88 -> m_rd_req=1, m_addr=0x1FC0_0020; one-cycle i_gnt with i_rd_line word0=0x11; d_gnt stays 0; DONE cycle shows m_rd_req=0.
- Simultaneous I and D read from reset, FIXED_PRIO=0 -> D served first (last_owner reset value I), then I; swap after each completion; 4 rounds alternate D,I,D,I.
- D write+read simultaneously, d_addr=0x0000_1000, d_wr_line word0=0xDEAD_BEEF -> m_wr_req first with m_wr_line word0=0xDEAD_BEEF; d_gnt; then m_rd_req for 0x0000_1000; second d_gnt.
- Requester changes i_addr to 0x2000 during BUSY -> m_addr stays at latched 0x1000 until gnt.
- aresetn pulled low mid-BUSY -> all outputs 0 immediately; after release, pending i_rd_req is re-arbitrated from IDLE.
- Spurious m_gnt in IDLE -> no i_gnt/d_gnt, state stays IDLE.
